// File: rtl/fp_conv_arbiter.sv
// fp_conv_arbiter
//   Round-robin arbiter and sequencer in front of one shared
//   floating_point_converter. A requester is granted, its 12-bit
//   two's-complement operand is registered, and the converted
//   sign/exponent/significand is returned over a valid/ready response port.
//
//   clk, rst                    clock, synchronous active-high reset
//   req[NUM_REQ]                per-requester level request
//   req_data[12*NUM_REQ]        operands, requester k at [12k+11:12k]
//   gnt[NUM_REQ]                one-hot pulse: operand captured
//   resp_valid / resp_ready     response handshake
//   resp_id, resp_s/e/f         tagged conversion result
//   busy                        registered (state != IDLE)

// floating_point_converter
//   D (12-bit two's complement) -> S, E (3-bit), F (4-bit), value ~ F * 2^E.
//   Magnitude is normalised so F holds the 4 bits starting at the leading one,
//   rounded by the next bit; -2048 and rounding overflow at E=7 saturate.
module floating_point_converter (
    input  logic [11:0] D,
    output logic        S,
    output logic [2:0]  E,
    output logic [3:0]  F
);
    logic [11:0] mag;
    logic [2:0]  e_raw;
    logic [12:0] ext;
    logic [4:0]  sum;

    always_comb begin
        S     = D[11];
        mag   = D[11] ? (~D + 12'd1) : D;
        if (D == 12'h800) begin
            mag = 12'h7FF;
        end

        // Exponent = position of the leading one minus 3 (0 when below 16).
        e_raw = '0;
        for (int unsigned i = 4; i < 11; i++) begin
            if (mag[i]) begin
                e_raw = 3'(i - 3);
            end
        end

        // One extra LSB carries the rounding bit through the shift.
        ext = {mag, 1'b0} >> e_raw;
        sum = {1'b0, ext[4:1]} + {4'b0, ext[0]};

        if (sum[4]) begin
            if (e_raw == 3'd7) begin
                E = 3'd7;
                F = 4'hF;
            end else begin
                E = e_raw + 3'd1;
                F = 4'b1000;
            end
        end else begin
            E = e_raw;
            F = sum[3:0];
        end
    end
endmodule

module fp_conv_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [12*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic                  resp_s,
    output logic [2:0]            resp_e,
    output logic [3:0]            resp_f,
    output logic                  busy
);
    typedef enum logic [1:0] {
        IDLE,
        CONV,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [11:0]        operand_q, operand_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic               resp_s_q, resp_s_d;
    logic [2:0]         resp_e_q, resp_e_d;
    logic [3:0]         resp_f_q, resp_f_d;
    logic               busy_q, busy_d;

    logic               conv_s;
    logic [2:0]         conv_e;
    logic [3:0]         conv_f;

    logic               found;
    logic [ID_W-1:0]    win;
    logic [ID_W-1:0]    win_next;
    int unsigned        idx;

    floating_point_converter u_conv (
        .D (operand_q),
        .S (conv_s),
        .E (conv_e),
        .F (conv_f)
    );

    // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = i + int'(rr_ptr_q);
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
        if (int'(win) == NUM_REQ - 1) begin
            win_next = '0;
        end else begin
            win_next = win + ID_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found)      state_d = CONV;
            CONV:                    state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        operand_d    = operand_q;
        id_d         = id_q;
        gnt_d        = '0;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_s_d     = resp_s_q;
        resp_e_d     = resp_e_q;
        resp_f_d     = resp_f_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    operand_d = req_data[int'(win)*12 +: 12];
                    id_d      = win;
                    gnt_d     = NUM_REQ'(1) << win;
                    rr_ptr_d  = win_next;
                end
            end
            CONV: begin
                resp_s_d     = conv_s;
                resp_e_d     = conv_e;
                resp_f_d     = conv_f;
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            operand_q    <= '0;
            id_q         <= '0;
            gnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_s_q     <= 1'b0;
            resp_e_q     <= '0;
            resp_f_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            operand_q    <= operand_d;
            id_q         <= id_d;
            gnt_q        <= gnt_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_s_q     <= resp_s_d;
            resp_e_q     <= resp_e_d;
            resp_f_q     <= resp_f_d;
            busy_q       <= busy_d;
        end
    end

    assign gnt        = gnt_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_s     = resp_s_q;
    assign resp_e     = resp_e_q;
    assign resp_f     = resp_f_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_fp_conv_arbiter.sv
module tb_fp_conv_arbiter;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [12*NR-1:0]  req_data = '0;
    logic              resp_ready = 1'b1;
    logic [NR-1:0]     gnt;
    logic              resp_valid;
    logic [IW-1:0]     resp_id;
    logic              resp_s;
    logic [2:0]        resp_e;
    logic [3:0]        resp_f;
    logic              busy;

    fp_conv_arbiter #(.NUM_REQ(NR), .ID_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_s     (resp_s),
        .resp_e     (resp_e),
        .resp_f     (resp_f),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [11:0] d;
        logic        s;
        logic [2:0]  e;
        logic [3:0]  f;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] r;
    } exp_t;

    logic [11:0] stim_data [NR];
    exp_t        sb [$];
    exp_t        ex;
    int          gq_id [$];
    int          gq_cyc [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference conversion: shift until the value fits 4 bits, round by the
    // last bit shifted out, renormalise on carry, saturate at E=7.
    function automatic logic [7:0] model(input logic [11:0] d);
        int m, e, f, s, r;
        s = int'(d[11]);
        m = int'(d);
        if (s != 0) m = 4096 - m;
        if (m > 2047) m = 2047;
        if (m < 16) return {s[0], 3'd0, m[3:0]};
        e = 0;
        while ((m >> e) > 15) e++;
        f = m >> e;
        r = (m >> (e - 1)) & 1;
        f = f + r;
        if (f == 16) begin
            f = 8;
            e = e + 1;
        end
        if (e > 7) begin
            e = 7;
            f = 15;
        end
        return {s[0], e[2:0], f[3:0]};
    endfunction

    // Monitor: scoreboard push on grant, pop on accepted response.
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt != '0) begin
                chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
                chk("gnt_with_valid", 32'(resp_valid), 32'd0);
                for (int k = 0; k < NR; k++) begin
                    if (gnt[k]) begin
                        gq_id.push_back(k);
                        gq_cyc.push_back(cyc);
                        sb.push_back('{k, model(stim_data[k])});
                    end
                end
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got response id %0d expected none", resp_id);
                end else begin
                    ex = sb.pop_front();
                    chk("sb_id", 32'(resp_id), 32'(ex.id));
                    chk("sb_sef", 32'({resp_s, resp_e, resp_f}), 32'(ex.r));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [11:0] d);
        stim_data[k] = d;
        req_data[12*k +: 12] = d;
        req[k] = 1'b1;
    endtask

    task automatic drop_req(input int k);
        req[k] = 1'b0;
        req_data[12*k +: 12] = ~stim_data[k];
    endtask

    // Raise req[k], wait (bounded) for its grant, then drop it.
    task automatic request(input int k, input logic [11:0] d, output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        set_req(k, d);
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            lat++;
            if (gnt[k]) ok = 1'b1;
        end
        chk("gnt_seen", 32'(ok), 32'd1);
        drop_req(k);
    endtask

    task automatic wait_resp();
        bit ok;
        ok = resp_valid;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            ok = resp_valid;
        end
        chk("resp_seen", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = !busy && !resp_valid && gnt == '0;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            ok = !busy && !resp_valid && gnt == '0;
        end
        chk("idle_seen", 32'(ok), 32'd1);
    endtask

    // Step until n grants are logged, dropping each requester after its grant.
    task automatic run_grants(input int n);
        for (int i = 0; i < 60 && gq_id.size() < n; i++) begin
            step();
            for (int k = 0; k < NR; k++) begin
                if (gnt[k]) drop_req(k);
            end
        end
        chk("grant_count", 32'(gq_id.size()), 32'(n));
        wait_idle();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_id"}, 32'(resp_id), 32'd0);
        chk({tag, "_sef"}, 32'({resp_s, resp_e, resp_f}), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    vec_t vecs [11];
    int   lat;
    logic [IW-1:0] h_id;
    logic [7:0]    h_sef;

    initial begin
        vecs[0]  = '{0, 12'd422,  1'b0, 3'd5, 4'd13};
        vecs[1]  = '{2, 12'hE5A,  1'b1, 3'd5, 4'd13};
        vecs[2]  = '{1, 12'd5,    1'b0, 3'd0, 4'd5};
        vecs[3]  = '{3, 12'h800,  1'b1, 3'd7, 4'd15};
        vecs[4]  = '{0, 12'h7FF,  1'b0, 3'd7, 4'd15};
        vecs[5]  = '{1, 12'd0,    1'b0, 3'd0, 4'd0};
        vecs[6]  = '{2, 12'd15,   1'b0, 3'd0, 4'd15};
        vecs[7]  = '{3, 12'd16,   1'b0, 3'd1, 4'd8};
        vecs[8]  = '{0, 12'd31,   1'b0, 3'd2, 4'd8};
        vecs[9]  = '{1, 12'hFFF,  1'b1, 3'd0, 4'd1};
        vecs[10] = '{2, 12'd1000, 1'b0, 3'd7, 4'd8};

        // Reset state
        step();
        step();
        check_zero_outputs("reset");
        rst = 1'b0;
        step();

        // Single request: latency and first result
        request(0, 12'd422, lat);
        chk("single_gnt_latency", 32'(lat), 32'd1);
        step();
        chk("single_valid_latency", 32'(resp_valid), 32'd1);
        chk("single_id", 32'(resp_id), 32'd0);
        chk("single_sef", 32'({resp_s, resp_e, resp_f}), {24'd0, 1'b0, 3'd5, 4'd13});
        step();
        chk("single_busy_after", 32'(busy), 32'd0);
        wait_idle();

        // Table-driven conversions
        foreach (vecs[i]) begin
            request(vecs[i].id, vecs[i].d, lat);
            wait_resp();
            chk("vec_id", 32'(resp_id), 32'(vecs[i].id));
            chk("vec_sef", 32'({resp_s, resp_e, resp_f}),
                32'({vecs[i].s, vecs[i].e, vecs[i].f}));
            step();
            chk("vec_accept", 32'(resp_valid), 32'd0);
            wait_idle();
        end

        // All four requesting from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        gq_id.delete();
        gq_cyc.delete();
        set_req(0, 12'd100);
        set_req(1, 12'hF00);
        set_req(2, 12'd7);
        set_req(3, 12'd2000);
        run_grants(4);
        for (int i = 0; i < 4 && i < gq_id.size(); i++) begin
            chk("all4_order", 32'(gq_id[i]), 32'(i));
            if (i > 0) chk("all4_gap", 32'(gq_cyc[i] - gq_cyc[i-1]), 32'd3);
        end

        // Round-robin wrap: after grant to 2, 0 and 2 request together
        request(2, 12'd300, lat);
        wait_idle();
        gq_id.delete();
        gq_cyc.delete();
        set_req(0, 12'd55);
        set_req(2, 12'h9AB);
        run_grants(2);
        if (gq_id.size() == 2) begin
            chk("wrap_first", 32'(gq_id[0]), 32'd0);
            chk("wrap_second", 32'(gq_id[1]), 32'd2);
        end

        // Backpressure with req[1] pending
        request(0, 12'd777, lat);
        resp_ready = 1'b0;
        set_req(1, 12'd64);
        step();
        chk("bp_valid", 32'(resp_valid), 32'd1);
        h_id  = resp_id;
        h_sef = {resp_s, resp_e, resp_f};
        chk("bp_sef", 32'(h_sef), 32'(model(12'd777)));
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", 32'(resp_valid), 32'd1);
            chk("bp_hold_id", 32'(resp_id), 32'(h_id));
            chk("bp_hold_sef", 32'({resp_s, resp_e, resp_f}), 32'(h_sef));
            chk("bp_no_gnt", 32'(gnt), 32'd0);
        end
        resp_ready = 1'b1;
        step();
        chk("bp_accept_valid", 32'(resp_valid), 32'd0);
        chk("bp_accept_gnt", 32'(gnt), 32'd0);
        step();
        chk("bp_next_gnt", 32'(gnt), 32'b0010);
        drop_req(1);
        wait_idle();

        // Reset during CONV; pointer left at 2 beforehand
        request(1, 12'd900, lat);
        rst = 1'b1;
        step();
        check_zero_outputs("midrst");
        rst = 1'b0;
        sb.delete();
        step();
        chk("midrst_no_valid", 32'(resp_valid), 32'd0);
        gq_id.delete();
        gq_cyc.delete();
        set_req(0, 12'd12);
        set_req(3, 12'hABC);
        run_grants(2);
        if (gq_id.size() == 2) begin
            chk("midrst_first", 32'(gq_id[0]), 32'd0);
            chk("midrst_second", 32'(gq_id[1]), 32'd3);
        end

        wait_idle();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
